// File: rtl/uart_cmd_framer_pkg.sv
// Shared opcode constants, error status defaults and state encodings for the
// UART command framer and its byte sender.
package uart_cmd_framer_pkg;

    localparam logic [7:0] OP_SET_KEY     = 8'h00;
    localparam logic [7:0] OP_ENC         = 8'h02;
    localparam logic [7:0] OP_DEC         = 8'h03;
    localparam logic [7:0] ERR_OP_DEFAULT = 8'hEE;
    localparam logic [7:0] ERR_TO_DEFAULT = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_DATA  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_RSP  = 3'd3,
        ST_SEND_STAT = 3'd4,
        ST_SEND_DATA = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SND_IDLE = 2'd0,
        SND_REQ  = 2'd1,
        SND_WAIT = 2'd2
    } snd_state_t;

    function automatic logic is_known_op(input logic [7:0] op);
        return (op == OP_SET_KEY) || (op == OP_ENC) || (op == OP_DEC);
    endfunction

    // Only ENC and DEC return a result block after the status byte.
    function automatic logic has_result(input logic [7:0] op);
        return (op == OP_ENC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/uart_cmd_framer_sender.sv
// One-byte transmit handshake towards the UART transmitter: request once when
// the transmitter is idle, then hold the byte until it reports completion.
module uart_byte_sender
    import uart_cmd_framer_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i_fStart,
    input  logic [7:0] i_Byte,
    input  logic       i_fTxReady,
    input  logic       i_fTxDone,
    output logic       o_fTx,
    output logic [7:0] o_TxData,
    output logic       o_fDone,
    output snd_state_t o_State
);

    // Handshake: i_fStart is taken only in SND_IDLE and latches i_Byte; o_fTx
    // pulses for the single cycle in which SND_REQ sees i_fTxReady high; no
    // further o_fTx until i_fTxDone, which also yields the one-cycle o_fDone.
    snd_state_t state, state_nxt;
    logic [7:0] byte_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= SND_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            byte_q <= 8'h00;
        end else if ((state == SND_IDLE) && i_fStart) begin
            byte_q <= i_Byte;
        end
    end

    always_comb begin
        state_nxt = state;
        o_fTx     = 1'b0;
        o_fDone   = 1'b0;
        case (state)
            SND_IDLE: begin
                if (i_fStart) state_nxt = SND_REQ;
            end
            SND_REQ: begin
                if (i_fTxReady) begin
                    o_fTx     = 1'b1;
                    state_nxt = SND_WAIT;
                end
            end
            SND_WAIT: begin
                if (i_fTxDone) begin
                    o_fDone   = 1'b1;
                    state_nxt = SND_IDLE;
                end
            end
            default: state_nxt = SND_IDLE;
        endcase
    end

    assign o_TxData = byte_q;
    assign o_State  = state;

endmodule

// File: rtl/uart_cmd_framer.sv
// Frames opcode + payload bytes from a UART into one command for the crypto
// core, then returns the status byte and, for ENC/DEC, the result block.
module uart_cmd_framer
    import uart_cmd_framer_pkg::*;
#(
    parameter int         DW      = 128,
    parameter int         TIMEOUT = 50000,
    parameter logic [7:0] ERR_OP  = ERR_OP_DEFAULT,
    parameter logic [7:0] ERR_TO  = ERR_TO_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          i_fRxDone,
    input  logic [7:0]    i_RxData,
    output logic          o_fTx,
    output logic [7:0]    o_TxData,
    input  logic          i_fTxReady,
    input  logic          i_fTxDone,
    output logic          o_fCmd,
    output logic [7:0]    o_Op,
    output logic [DW-1:0] o_Data,
    input  logic          i_fRsp,
    input  logic [7:0]    i_Status,
    input  logic [DW-1:0] i_RspData,
    output logic          o_fBusy,
    output state_t        o_State,
    output snd_state_t    o_SndState
);

    localparam int NB     = DW / 8;
    localparam int BCW    = $clog2(NB) + 1;
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW > 18) ? CW_RAW : 18;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
    localparam logic [CW-1:0]  TO_LIM    = CW'(TIMEOUT);

    state_t          state, state_nxt;
    logic [7:0]      op_q;
    logic [7:0]      status_q;
    logic [DW-1:0]   data_q;
    logic [DW-1:0]   rsp_q;
    logic [BCW-1:0]  byte_cnt;
    logic [CW-1:0]   idle_cnt;
    logic            snd_pend;

    logic            rx_take;
    logic            to_hit;
    logic            rsp_take;
    logic            snd_start;
    logic            snd_done;
    logic [7:0]      snd_byte;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_take   = 1'b0;
        to_hit    = 1'b0;
        rsp_take  = 1'b0;
        snd_start = 1'b0;
        o_fCmd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_fRxDone) begin
                    state_nxt = is_known_op(i_RxData) ? ST_GET_DATA : ST_SEND_STAT;
                end
            end
            ST_GET_DATA: begin
                // A byte landing on the timeout cycle wins over the timeout.
                if (i_fRxDone) begin
                    rx_take = 1'b1;
                    if (byte_cnt == LAST_BYTE) state_nxt = ST_ISSUE;
                end else if (idle_cnt == TO_LIM) begin
                    to_hit    = 1'b1;
                    state_nxt = ST_SEND_STAT;
                end
            end
            ST_ISSUE: begin
                o_fCmd    = 1'b1;
                state_nxt = ST_WAIT_RSP;
            end
            ST_WAIT_RSP: begin
                if (i_fRsp) begin
                    rsp_take  = 1'b1;
                    state_nxt = ST_SEND_STAT;
                end
            end
            ST_SEND_STAT: begin
                snd_start = !snd_pend;
                if (snd_done) begin
                    state_nxt = (has_result(op_q) && (status_q == 8'h00)) ? ST_SEND_DATA : ST_IDLE;
                end
            end
            ST_SEND_DATA: begin
                snd_start = !snd_pend;
                if (snd_done && (byte_cnt == LAST_BYTE)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q     <= 8'h00;
            status_q <= 8'h00;
            data_q   <= '0;
            rsp_q    <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            snd_pend <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && i_fRxDone) begin
                op_q <= i_RxData;
                if (!is_known_op(i_RxData)) status_q <= ERR_OP;
            end
            if (rx_take) data_q <= (data_q << 8) | DW'(i_RxData);
            if (to_hit) begin
                data_q   <= '0;
                status_q <= ERR_TO;
            end
            if (rsp_take) begin
                status_q <= i_Status;
                rsp_q    <= i_RspData;
            end
            if ((state == ST_SEND_DATA) && snd_done) rsp_q <= rsp_q << 8;

            if ((state == ST_GET_DATA) && !i_fRxDone && (idle_cnt != TO_LIM)) begin
                idle_cnt <= idle_cnt + CW'(1);
            end else begin
                idle_cnt <= '0;
            end

            // The byte counter never survives a state change.
            if (state_nxt != state) begin
                byte_cnt <= '0;
            end else if (rx_take || ((state == ST_SEND_DATA) && snd_done)) begin
                byte_cnt <= byte_cnt + BCW'(1);
            end

            if (snd_start) begin
                snd_pend <= 1'b1;
            end else if (snd_done) begin
                snd_pend <= 1'b0;
            end
        end
    end

    assign snd_byte = (state == ST_SEND_STAT) ? status_q : rsp_q[DW-1 -: 8];

    uart_byte_sender u_sender (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_fStart   (snd_start),
        .i_Byte     (snd_byte),
        .i_fTxReady (i_fTxReady),
        .i_fTxDone  (i_fTxDone),
        .o_fTx      (o_fTx),
        .o_TxData   (o_TxData),
        .o_fDone    (snd_done),
        .o_State    (o_SndState)
    );

    assign o_Op    = op_q;
    assign o_Data  = data_q;
    assign o_fBusy = (state != ST_IDLE);
    assign o_State = state;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Bench for uart_cmd_framer: a 128-bit and a 64-bit instance driven with fixed
// and random frames, with replies checked against a frame-level reference model.
module tb_uart_cmd_framer;
    import uart_cmd_framer_pkg::*;

    localparam int TO = 200;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    logic       rx_dn[2];
    logic [7:0] rx_byte[2];
    logic       tx_req[2];
    logic [7:0] tx_byte[2];
    logic       tx_rdy[2] = '{1'b1, 1'b1};
    logic       tx_dn[2]  = '{1'b0, 1'b0};
    logic       cmd[2];
    logic [7:0] op_o[2];
    logic       rsp_v[2];
    logic [7:0] stat_i[2];
    logic       busy[2];
    logic [127:0] data_a, rspd_a;
    logic [63:0]  data_b, rspd_b;
    state_t     st_a, st_b;
    snd_state_t sst_a, sst_b;

    int total = 0;
    int bad = 0;
    int proto_err = 0;
    int hold_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got0_q[$];
    logic [7:0] got1_q[$];

    int           cmd_cnt[2] = '{0, 0};
    logic [7:0]   cmd_op[2];
    logic [127:0] cmd_data[2];

    logic [7:0] tx_hold[2];
    int         tx_wait[2];
    logic       tx_busy[2] = '{1'b0, 1'b0};

    uart_cmd_framer #(.DW(128), .TIMEOUT(TO)) dut_a (
        .Clk(Clk), .Rst(Rst),
        .i_fRxDone(rx_dn[0]), .i_RxData(rx_byte[0]),
        .o_fTx(tx_req[0]), .o_TxData(tx_byte[0]),
        .i_fTxReady(tx_rdy[0]), .i_fTxDone(tx_dn[0]),
        .o_fCmd(cmd[0]), .o_Op(op_o[0]), .o_Data(data_a),
        .i_fRsp(rsp_v[0]), .i_Status(stat_i[0]), .i_RspData(rspd_a),
        .o_fBusy(busy[0]), .o_State(st_a), .o_SndState(sst_a)
    );

    uart_cmd_framer #(.DW(64), .TIMEOUT(TO)) dut_b (
        .Clk(Clk), .Rst(Rst),
        .i_fRxDone(rx_dn[1]), .i_RxData(rx_byte[1]),
        .o_fTx(tx_req[1]), .o_TxData(tx_byte[1]),
        .i_fTxReady(tx_rdy[1]), .i_fTxDone(tx_dn[1]),
        .o_fCmd(cmd[1]), .o_Op(op_o[1]), .o_Data(data_b),
        .i_fRsp(rsp_v[1]), .i_Status(stat_i[1]), .i_RspData(rspd_b),
        .o_fBusy(busy[1]), .o_State(st_b), .o_SndState(sst_b)
    );

    // ---------------- clock / reset ----------------
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- UART transmitter model ----------------
    // Inputs change on the falling edge; the request is sampled #1 later, i.e.
    // with the ready value the DUT sees at the next rising edge.
    always begin
        @(negedge Clk);
        for (int k = 0; k < 2; k++) begin
            tx_dn[k] = 1'b0;
            if (!Rst) begin
                tx_busy[k] = 1'b0;
                tx_rdy[k]  = 1'b1;
            end else if (tx_busy[k]) begin
                tx_rdy[k] = 1'b0;
                if (tx_byte[k] !== tx_hold[k]) hold_err++;
                if (tx_wait[k] == 0) begin
                    tx_dn[k]   = 1'b1;
                    tx_busy[k] = 1'b0;
                    tx_rdy[k]  = 1'b1;
                    if (k == 0) got0_q.push_back(tx_hold[k]);
                    else        got1_q.push_back(tx_hold[k]);
                end else begin
                    tx_wait[k]--;
                end
            end else if (!tx_dn[k]) begin
                tx_rdy[k] = ($urandom_range(0, 3) != 0);
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            if (Rst && tx_req[k]) begin
                if (tx_busy[k] || tx_dn[k] || !tx_rdy[k]) begin
                    proto_err++;
                end else begin
                    tx_hold[k] = tx_byte[k];
                    tx_busy[k] = 1'b1;
                    tx_wait[k] = $urandom_range(1, 5);
                end
            end
        end
    end

    // Command monitor: counts o_fCmd pulses and captures what the core sees.
    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cmd[k]) begin
                cmd_cnt[k]++;
                cmd_op[k]   = op_o[k];
                cmd_data[k] = (k == 0) ? data_a : {64'd0, data_b};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        @(negedge Clk);
        rx_dn[k]   = 1'b1;
        rx_byte[k] = b;
        @(negedge Clk);
        rx_dn[k]   = 1'b0;
    endtask

    task automatic send_rsp(input int k, input logic [7:0] s, input logic [127:0] r);
        @(negedge Clk);
        rsp_v[k]  = 1'b1;
        stat_i[k] = s;
        if (k == 0) rspd_a = r;
        else        rspd_b = r[63:0];
        @(negedge Clk);
        rsp_v[k]  = 1'b0;
    endtask

    function automatic int got_size(input int k);
        return (k == 0) ? got0_q.size() : got1_q.size();
    endfunction

    function automatic logic [7:0] got_pop(input int k);
        return (k == 0) ? got0_q.pop_front() : got1_q.pop_front();
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Sends one frame, plays the core, and scores the reply against the model:
    // unknown op -> ERR_OP only; otherwise status, plus NB result bytes MSB
    // first when the op is ENC/DEC and the status is zero.
    task automatic run_frame(input int k, input logic [7:0] op, input logic [127:0] payload,
                             input logic [7:0] status, input logic [127:0] result,
                             input bit stray, input int long_gap_at, input string name);
        int nb, c0, n, exp_n;
        bit known;
        logic [127:0] exp_data;
        logic [7:0] g, e;
        nb    = (k == 0) ? 16 : 8;
        known = (op == 8'h00) || (op == 8'h02) || (op == 8'h03);
        exp_q.delete();
        if (!known) begin
            exp_q.push_back(8'hEE);
        end else begin
            exp_q.push_back(status);
            if ((op != 8'h00) && (status == 8'h00))
                for (int i = 0; i < nb; i++) exp_q.push_back(result[(nb-1-i)*8 +: 8]);
        end
        exp_n    = exp_q.size();
        exp_data = (nb == 16) ? payload : {64'd0, payload[63:0]};
        if (k == 0) got0_q.delete();
        else        got1_q.delete();
        c0 = cmd_cnt[k];

        send_byte(k, op);
        if (known) begin
            for (int j = 0; j < nb; j++) begin
                if (j == long_gap_at) idle(TO - 1);
                else                  idle($urandom_range(0, 3));
                send_byte(k, payload[(nb-1-j)*8 +: 8]);
            end
            n = 0;
            while ((cmd_cnt[k] == c0) && (n < 100)) begin
                @(negedge Clk);
                n++;
            end
            total++;
            if (cmd_cnt[k] != c0 + 1)
                $display("FAIL %s cmd_pulse: got %0d pulses, want 1", name, cmd_cnt[k] - c0);
            if (cmd_cnt[k] != c0 + 1) bad++;
            total++;
            if (cmd_op[k] !== op) begin
                bad++;
                $display("FAIL %s cmd_op: got %02h, want %02h", name, cmd_op[k], op);
            end
            total++;
            if (cmd_data[k] !== exp_data) begin
                bad++;
                $display("FAIL %s cmd_data: got %032h, want %032h", name, cmd_data[k], exp_data);
            end
            idle($urandom_range(0, 4));
            if (stray) begin
                send_byte(k, 8'h05);
                idle(2);
            end
            send_rsp(k, status, result);
        end

        n = 0;
        while (((got_size(k) < exp_n) || busy[k]) && (n < 4000)) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (got_size(k) != exp_n) begin
            bad++;
            $display("FAIL %s reply_len: got %0d bytes, want %0d", name, got_size(k), exp_n);
        end
        for (int i = 0; (i < exp_n) && (got_size(k) > 0); i++) begin
            g = got_pop(k);
            e = exp_q.pop_front();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL %s reply_byte[%0d]: got %02h, want %02h", name, i, g, e);
            end
        end
        idle(10);
        total++;
        if ((got_size(k) != 0) || busy[k]) begin
            bad++;
            $display("FAIL %s quiet_after: got %0d extra bytes busy=%0b, want 0 and 0",
                     name, got_size(k), busy[k]);
        end
        total++;
        if (cmd_cnt[k] - c0 != (known ? 1 : 0)) begin
            bad++;
            $display("FAIL %s cmd_total: got %0d, want %0d", name, cmd_cnt[k] - c0, known ? 1 : 0);
        end
        total++;
        if (op_o[k] !== op) begin
            bad++;
            $display("FAIL %s op_held: got %02h, want %02h", name, op_o[k], op);
        end
        if (known) begin
            total++;
            if (((k == 0) ? data_a : {64'd0, data_b}) !== exp_data) begin
                bad++;
                $display("FAIL %s data_held: got %032h, want %032h", name,
                         (k == 0) ? data_a : {64'd0, data_b}, exp_data);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(2);
        total++;
        if ({tx_req[0], cmd[0], busy[0], tx_req[1], cmd[1], busy[1]} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %06b, want 000000",
                     {tx_req[0], cmd[0], busy[0], tx_req[1], cmd[1], busy[1]});
        end
        total++;
        if ({tx_byte[0], op_o[0], tx_byte[1], op_o[1]} !== 32'h0) begin
            bad++;
            $display("FAIL reset_bytes: got %08h, want 00000000",
                     {tx_byte[0], op_o[0], tx_byte[1], op_o[1]});
        end
        total++;
        if ((data_a !== 128'h0) || (data_b !== 64'h0)) begin
            bad++;
            $display("FAIL reset_data: got %032h / %016h, want 0", data_a, data_b);
        end
        total++;
        if ((st_a !== ST_IDLE) || (st_b !== ST_IDLE)) begin
            bad++;
            $display("FAIL reset_state: got %0d / %0d, want 0", st_a, st_b);
        end
        Rst = 1'b1;
        idle(3);
    endtask

    task automatic test_set_key();
        run_frame(0, 8'h00, 128'h54686174_73206D79_204B756E_67204675, 8'h00, rand128(), 0, -1, "set_key");
    endtask

    task automatic test_enc_vector();
        run_frame(0, 8'h02, 128'h54776F20_4F6E6520_4E696E65_2054776F, 8'h00,
                  128'h29C3505F_571420F6_402299B3_1A02D73A, 0, -1, "enc_vector");
    endtask

    task automatic test_bad_opcode();
        run_frame(0, 8'h05, rand128(), 8'h00, rand128(), 0, -1, "bad_op");
        run_frame(0, 8'h02, rand128(), 8'h00, rand128(), 0, -1, "enc_after_bad_op");
    endtask

    task automatic test_timeout();
        int c0, n;
        got0_q.delete();
        c0 = cmd_cnt[0];
        send_byte(0, 8'h03);
        for (int j = 0; j < 5; j++) begin
            idle($urandom_range(0, 3));
            send_byte(0, 8'($urandom));
        end
        idle(TO);
        n = 0;
        while (((got0_q.size() < 1) || busy[0]) && (n < 500)) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if ((got0_q.size() != 1) || (got0_q[0] !== 8'hE0)) begin
            bad++;
            $display("FAIL timeout_reply: got %0d bytes first=%02h, want 1 byte E0",
                     got0_q.size(), (got0_q.size() > 0) ? got0_q[0] : 8'hxx);
        end
        total++;
        if (cmd_cnt[0] != c0) begin
            bad++;
            $display("FAIL timeout_cmd: got %0d pulses, want 0", cmd_cnt[0] - c0);
        end
        total++;
        if (data_a !== 128'h0) begin
            bad++;
            $display("FAIL timeout_discard: got %032h, want 0", data_a);
        end
        got0_q.delete();
        run_frame(0, 8'h03, rand128(), 8'h00, rand128(), 0, -1, "dec_after_timeout");
    endtask

    task automatic test_gap_boundary();
        run_frame(0, 8'h02, rand128(), 8'h00, rand128(), 0, 0, "gap_at_first");
        run_frame(0, 8'h03, rand128(), 8'h00, rand128(), 0, 9, "gap_mid");
    endtask

    task automatic test_stray();
        got0_q.delete();
        send_rsp(0, 8'h00, rand128());
        idle(5);
        total++;
        if (busy[0] || (got0_q.size() != 0)) begin
            bad++;
            $display("FAIL stray_rsp: got busy=%0b bytes=%0d, want 0 and 0", busy[0], got0_q.size());
        end
        run_frame(0, 8'h02, rand128(), 8'h00, rand128(), 1, -1, "stray_rx");
    endtask

    task automatic test_reset_mid_reply();
        logic [127:0] pl, res;
        logic [55:0] got7;
        int c0, n;
        pl  = rand128();
        res = rand128();
        got0_q.delete();
        c0 = cmd_cnt[0];
        send_byte(0, 8'h02);
        for (int j = 0; j < 16; j++) send_byte(0, pl[(15-j)*8 +: 8]);
        n = 0;
        while ((cmd_cnt[0] == c0) && (n < 100)) begin
            @(negedge Clk);
            n++;
        end
        send_rsp(0, 8'h00, res);
        n = 0;
        while (((got0_q.size() < 7) || !tx_busy[0]) && (n < 2000)) begin
            @(negedge Clk);
            n++;
        end
        got7 = '0;
        for (int i = 0; i < got0_q.size() && i < 7; i++) got7 = {got7[47:0], got0_q[i]};
        total++;
        if ((got0_q.size() != 7) || (got7 !== {8'h00, res[127:80]})) begin
            bad++;
            $display("FAIL rst_pre_bytes: got %0d bytes %014h, want 7 bytes %014h",
                     got0_q.size(), got7, {8'h00, res[127:80]});
        end
        Rst = 1'b0;
        #1;
        total++;
        if ({tx_req[0], cmd[0], busy[0]} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_flags: got %03b, want 000", {tx_req[0], cmd[0], busy[0]});
        end
        total++;
        if ({tx_byte[0], op_o[0]} !== 16'h0 || data_a !== 128'h0) begin
            bad++;
            $display("FAIL rst_mid_values: got tx=%02h op=%02h data=%032h, want 0",
                     tx_byte[0], op_o[0], data_a);
        end
        total++;
        if (st_a !== ST_IDLE) begin
            bad++;
            $display("FAIL rst_mid_state: got %0d, want 0", st_a);
        end
        idle(3);
        Rst = 1'b1;
        idle(2);
        got0_q.delete();
        run_frame(0, 8'h02, rand128(), 8'h00, rand128(), 0, -1, "enc_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] op, st;
        int r;
        for (int f = 0; f < 8; f++) begin
            r = $urandom_range(0, 7);
            if (r == 0)      op = 8'h00;
            else if (r < 4)  op = 8'h02;
            else if (r < 6)  op = 8'h03;
            else             op = 8'($urandom_range(4, 255));
            st = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(0, op, rand128(), st, rand128(), 0, -1, "back_to_back");
        end
    endtask

    task automatic test_dw64();
        run_frame(1, 8'h02, rand128(), 8'h00, rand128(), 0, -1, "dw64_enc");
        run_frame(1, 8'h03, rand128(), 8'h5A, rand128(), 0, -1, "dw64_dec_err");
    endtask

    task automatic test_tx_protocol();
        total++;
        if (proto_err != 0) begin
            bad++;
            $display("FAIL tx_handshake: got %0d violations, want 0", proto_err);
        end
        total++;
        if (hold_err != 0) begin
            bad++;
            $display("FAIL tx_data_hold: got %0d unstable cycles, want 0", hold_err);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rx_dn[k]   = 1'b0;
            rx_byte[k] = 8'h00;
            rsp_v[k]   = 1'b0;
            stat_i[k]  = 8'h00;
        end
        rspd_a = '0;
        rspd_b = '0;
        Rst    = 1'b0;
        test_reset();
        test_set_key();
        test_enc_vector();
        test_bad_opcode();
        test_timeout();
        test_gap_boundary();
        test_stray();
        test_reset_mid_reply();
        test_back_to_back();
        test_dw64();
        test_tx_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
